// File: rtl/ad80305_rx_if_deframer.sv
// ---------------------------------------------------------------------------
// ad80305_rx_if_deframer
//
// Receive-side deframer for the AD80305 6-bit DDR LVCMOS data port. It takes
// the rising/falling-edge lanes already captured by the DDR input register.
// The rising-edge half is the I lane and the falling-edge half is the Q lane.
// It aligns to the frame bit: frame=1/1 marks the MSB-half cycle and frame=0/0
// marks the LSB-half cycle. It rebuilds 12-bit I/Q samples (one per two clocks)
// and tracks lock and frame errors.
//
// Ports
//   i_rx_clk         rx data clock, sole clock
//   i_fpga_rst       synchronous reset, active-high, dominant
//   i_rx_frame_h/_l  frame bit captured on rising / falling edge
//   i_rx_data_h/_l   6-bit data halves, rising (I) / falling (Q) edge
//   i_err_clr        single-cycle pulse clearing o_frame_err_cnt
//   o_rx_iqdata_fp   one-cycle strobe: new sample on o_rx_idata/o_rx_qdata
//   o_rx_idata       {MSB-cycle h, LSB-cycle h}
//   o_rx_qdata       {MSB-cycle l, LSB-cycle l}
//   o_lock           deframer aligned and locked
//   o_frame_err_cnt  saturating frame-error count
// ---------------------------------------------------------------------------
module ad80305_rx_if_deframer #(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic             i_rx_clk,
    input  logic             i_fpga_rst,
    input  logic             i_rx_frame_h,
    input  logic             i_rx_frame_l,
    input  logic [5:0]       i_rx_data_h,
    input  logic [5:0]       i_rx_data_l,
    input  logic             i_err_clr,
    output logic             o_rx_iqdata_fp,
    output logic [11:0]      o_rx_idata,
    output logic [11:0]      o_rx_qdata,
    output logic             o_lock,
    output logic [ERR_W-1:0] o_frame_err_cnt
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam int ER_W = $clog2(UNLOCK_CNT + 1);

    // Counter values compared against the *current* count, so that the
    // transition happens on the edge that completes the run.
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(LOCK_CNT - 1);
    localparam logic [ER_W-1:0] ER_LAST = ER_W'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_LSB  = 2'd1,
        S_MSB  = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [5:0]        msb_h_q,   msb_h_d;
    logic [5:0]        msb_l_q,   msb_l_d;
    logic [GC_W-1:0]   good_cnt_q, good_cnt_d;
    logic [ER_W-1:0]   err_run_q, err_run_d;
    logic              lock_q,    lock_d;
    logic              fp_q,      fp_d;
    logic [11:0]       idata_q,   idata_d;
    logic [11:0]       qdata_q,   qdata_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic is_msb_s;
    logic is_lsb_s;
    logic latch_msb_s;
    logic good_pair_s;
    logic frame_err_s;

    // Frame classification, alignment FSM and MSB-half capture.
    always_comb begin
        is_msb_s    = i_rx_frame_h & i_rx_frame_l;
        is_lsb_s    = ~i_rx_frame_h & ~i_rx_frame_l;
        state_d     = state_q;
        latch_msb_s = 1'b0;
        good_pair_s = 1'b0;
        frame_err_s = 1'b0;

        case (state_q)
            S_HUNT: begin
                // Hunting never counts errors; only an MSB cycle starts a pair.
                if (is_msb_s) begin
                    latch_msb_s = 1'b1;
                    state_d     = S_LSB;
                end else begin
                    state_d = S_HUNT;
                end
            end
            S_LSB: begin
                if (is_lsb_s) begin
                    good_pair_s = 1'b1;
                    state_d     = S_MSB;
                end else if (is_msb_s) begin
                    // Unexpected MSB: count it, but treat it as a fresh pair start.
                    frame_err_s = 1'b1;
                    latch_msb_s = 1'b1;
                    state_d     = S_LSB;
                end else begin
                    frame_err_s = 1'b1;
                    state_d     = S_HUNT;
                end
            end
            S_MSB: begin
                if (is_msb_s) begin
                    latch_msb_s = 1'b1;
                    state_d     = S_LSB;
                end else begin
                    // Not an MSB cycle, so the error cannot re-align here.
                    frame_err_s = 1'b1;
                    state_d     = S_HUNT;
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        if (latch_msb_s) begin
            msb_h_d = i_rx_data_h;
            msb_l_d = i_rx_data_l;
        end else begin
            msb_h_d = msb_h_q;
            msb_l_d = msb_l_q;
        end
    end

    // Sample assembly and lock-gated strobe generation.
    always_comb begin
        // The strobe uses the lock state of the LSB cycle itself.
        // As a result, the pair that completes lock is not strobed.
        fp_d = good_pair_s & lock_q;
        if (good_pair_s) begin
            idata_d = {msb_h_q, i_rx_data_h};
            qdata_d = {msb_l_q, i_rx_data_l};
        end else begin
            idata_d = idata_q;
            qdata_d = qdata_q;
        end
    end

    // Lock acquisition (good-pair run) and loss (error run while locked).
    always_comb begin
        lock_d     = lock_q;
        good_cnt_d = good_cnt_q;
        err_run_d  = err_run_q;
        if (!lock_q) begin
            if (frame_err_s) begin
                good_cnt_d = {GC_W{1'b0}};
            end else if (good_pair_s) begin
                good_cnt_d = good_cnt_q + GC_W'(1);
                if (good_cnt_q == GC_LAST) begin
                    lock_d = 1'b1;
                end else begin
                    lock_d = 1'b0;
                end
            end else begin
                good_cnt_d = good_cnt_q;
            end
        end else begin
            // good_cnt stays frozen while locked.
            if (good_pair_s) begin
                err_run_d = {ER_W{1'b0}};
            end else if (frame_err_s) begin
                if (err_run_q == ER_LAST) begin
                    lock_d     = 1'b0;
                    good_cnt_d = {GC_W{1'b0}};
                    err_run_d  = {ER_W{1'b0}};
                end else begin
                    err_run_d = err_run_q + ER_W'(1);
                end
            end else begin
                err_run_d = err_run_q;
            end
        end
    end

    // Saturating frame-error counter; an error coinciding with clear still counts.
    always_comb begin
        if (i_err_clr) begin
            err_cnt_d = frame_err_s ? ERR_W'(1) : {ERR_W{1'b0}};
        end else if (frame_err_s && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers with synchronous dominant reset.
    always_ff @(posedge i_rx_clk) begin
        if (i_fpga_rst) begin
            state_q    <= S_HUNT;
            msb_h_q    <= 6'd0;
            msb_l_q    <= 6'd0;
            good_cnt_q <= {GC_W{1'b0}};
            err_run_q  <= {ER_W{1'b0}};
            lock_q     <= 1'b0;
            fp_q       <= 1'b0;
            idata_q    <= 12'd0;
            qdata_q    <= 12'd0;
            err_cnt_q  <= {ERR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            msb_h_q    <= msb_h_d;
            msb_l_q    <= msb_l_d;
            good_cnt_q <= good_cnt_d;
            err_run_q  <= err_run_d;
            lock_q     <= lock_d;
            fp_q       <= fp_d;
            idata_q    <= idata_d;
            qdata_q    <= qdata_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_rx_iqdata_fp  = fp_q;
    assign o_rx_idata      = idata_q;
    assign o_rx_qdata      = qdata_q;
    assign o_lock          = lock_q;
    assign o_frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ad80305_rx_if_deframer.sv
// ---------------------------------------------------------------------------
// Testbench for ad80305_rx_if_deframer (built with ERR_W=4 so that saturation
// is reachable). Each vector is applied for one clock, and the registered
// outputs are compared 1 time unit after that edge.
// ---------------------------------------------------------------------------
module tb_ad80305_rx_if_deframer;

    localparam int ERR_W = 4;

    localparam logic [5:0]  MH = 6'h29;
    localparam logic [5:0]  ML = 6'h0F;
    localparam logic [5:0]  LH = 6'h1C;
    localparam logic [5:0]  LL = 6'h31;
    localparam logic [11:0] IA = 12'hA5C;
    localparam logic [11:0] QA = 12'h3F1;
    localparam logic [11:0] IB = 12'hFC0;
    localparam logic [11:0] QB = 12'h03F;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             frame_h = 1'b0;
    logic             frame_l = 1'b0;
    logic [5:0]       data_h = 6'd0;
    logic [5:0]       data_l = 6'd0;
    logic             err_clr = 1'b0;
    logic             fp;
    logic [11:0]      idata;
    logic [11:0]      qdata;
    logic             lock;
    logic [ERR_W-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ad80305_rx_if_deframer #(
        .LOCK_CNT  (8),
        .UNLOCK_CNT(4),
        .ERR_W     (ERR_W)
    ) dut (
        .i_rx_clk       (clk),
        .i_fpga_rst     (rst),
        .i_rx_frame_h   (frame_h),
        .i_rx_frame_l   (frame_l),
        .i_rx_data_h    (data_h),
        .i_rx_data_l    (data_l),
        .i_err_clr      (err_clr),
        .o_rx_iqdata_fp (fp),
        .o_rx_idata     (idata),
        .o_rx_qdata     (qdata),
        .o_lock         (lock),
        .o_frame_err_cnt(err_cnt)
    );

    typedef struct {
        logic        fh;
        logic        fl;
        logic [5:0]  dh;
        logic [5:0]  dl;
        logic        clr;
        logic        rst;
        logic        efp;
        logic [11:0] ei;
        logic [11:0] eq;
        logic        elock;
        logic [3:0]  eerr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fh, input logic fl, input logic [5:0] dh,
                       input logic [5:0] dl, input logic clr, input logic rs,
                       input logic efp, input logic [11:0] ei, input logic [11:0] eq,
                       input logic elock, input logic [3:0] eerr);
        vec_t v;
        v.fh = fh; v.fl = fl; v.dh = dh; v.dl = dl; v.clr = clr; v.rst = rs;
        v.efp = efp; v.ei = ei; v.eq = eq; v.elock = elock; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic fh, input logic fl, input logic [5:0] dh,
                         input logic [5:0] dl, input logic clr, input logic rs);
        frame_h = fh; frame_l = fl; data_h = dh; data_l = dl;
        err_clr = clr; rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    initial begin
        logic [29:0] act_v;
        logic [29:0] exp_v;
        logic [3:0]  e_err;
        bit          locked_seen;

        // Reset, then idle/LSB and mismatched frame bits while hunting.
        add(1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 4'd0);
        for (int n = 0; n < 3; n++)
            add(1'b0, 1'b0, 6'h15, 6'h2A, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 4'd0);
        add(1'b1, 1'b0, MH, ML, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 4'd0);
        add(1'b0, 1'b1, MH, ML, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 4'd0);

        // Clean stream: lock after pair 8, first strobe after pair 9's LSB cycle.
        for (int k = 1; k <= 12; k++) begin
            add(1'b1, 1'b1, MH, ML, 1'b0, 1'b0, 1'b0,
                (k >= 2) ? IA : 12'h000, (k >= 2) ? QA : 12'h000, (k >= 9), 4'd0);
            add(1'b0, 1'b0, LH, LL, 1'b0, 1'b0, (k >= 9), IA, QA, (k >= 8), 4'd0);
        end

        // Locked: LSB replaced by 1/1; the error cycle becomes the new MSB.
        add(1'b1, 1'b1, MH, ML, 1'b0, 1'b0, 1'b0, IA, QA, 1'b1, 4'd0);
        add(1'b1, 1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, IA, QA, 1'b1, 4'd1);
        add(1'b0, 1'b0, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b1, IB, QB, 1'b1, 4'd1);
        add(1'b1, 1'b1, MH, ML, 1'b0, 1'b0, 1'b0, IB, QB, 1'b1, 4'd1);
        add(1'b0, 1'b0, LH, LL, 1'b0, 1'b0, 1'b1, IA, QA, 1'b1, 4'd1);

        // Clear, then four consecutive frame errors drop lock; relock after 8 pairs.
        add(1'b1, 1'b1, MH, ML, 1'b1, 1'b0, 1'b0, IA, QA, 1'b1, 4'd0);
        for (int n = 1; n <= 4; n++)
            add(1'b1, 1'b1, MH, ML, 1'b0, 1'b0, 1'b0, IA, QA, (n < 4), 4'(n));
        add(1'b0, 1'b0, LH, LL, 1'b0, 1'b0, 1'b0, IA, QA, 1'b0, 4'd4);
        for (int k = 2; k <= 9; k++) begin
            add(1'b1, 1'b1, MH, ML, 1'b0, 1'b0, 1'b0, IA, QA, (k >= 9), 4'd4);
            add(1'b0, 1'b0, LH, LL, 1'b0, 1'b0, (k >= 9), IA, QA, (k >= 8), 4'd4);
        end

        // Mismatched frame bits while locked: one error, back to hunting, lock held.
        add(1'b1, 1'b0, MH, ML, 1'b0, 1'b0, 1'b0, IA, QA, 1'b1, 4'd5);
        add(1'b1, 1'b1, MH, ML, 1'b0, 1'b0, 1'b0, IA, QA, 1'b1, 4'd5);
        add(1'b0, 1'b0, LH, LL, 1'b0, 1'b0, 1'b1, IA, QA, 1'b1, 4'd5);

        // Saturation: repeated MSB cycles in S_LSB are each an error.
        add(1'b1, 1'b1, MH, ML, 1'b0, 1'b0, 1'b0, IA, QA, 1'b1, 4'd5);
        for (int n = 1; n <= 12; n++) begin
            e_err = (5 + n > 15) ? 4'd15 : 4'(5 + n);
            add(1'b1, 1'b1, MH, ML, 1'b0, 1'b0, 1'b0, IA, QA, (n < 4), e_err);
        end
        add(1'b1, 1'b1, MH, ML, 1'b1, 1'b0, 1'b0, IA, QA, 1'b0, 4'd1);
        add(1'b0, 1'b0, LH, LL, 1'b1, 1'b0, 1'b0, IA, QA, 1'b0, 4'd0);

        // Reset mid-pair: the LSB half after reset must not complete a pair.
        add(1'b1, 1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, IA, QA, 1'b0, 4'd0);
        add(1'b0, 1'b0, 6'h00, 6'h3F, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 4'd0);
        add(1'b0, 1'b0, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 4'd0);
        add(1'b1, 1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 4'd0);
        add(1'b0, 1'b0, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b0, IB, QB, 1'b0, 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fh, vecs[i].fl, vecs[i].dh, vecs[i].dl, vecs[i].clr, vecs[i].rst);
            act_v = {fp, idata, qdata, lock, err_cnt};
            exp_v = {vecs[i].efp, vecs[i].ei, vecs[i].eq, vecs[i].elock, vecs[i].eerr};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL vec%0d: got fp=%0b i=%h q=%h lock=%0b err=%0d expected fp=%0b i=%h q=%h lock=%0b err=%0d",
                         i, fp, idata, qdata, lock, err_cnt,
                         vecs[i].efp, vecs[i].ei, vecs[i].eq, vecs[i].elock, vecs[i].eerr);
            end
        end

        // Hand sequence: relock with a bounded wait, then check the 2-cycle strobe cadence.
        locked_seen = 1'b0;
        for (int p = 0; p < 20 && !locked_seen; p++) begin
            drive(1'b1, 1'b1, MH, ML, 1'b0, 1'b0);
            drive(1'b0, 1'b0, LH, LL, 1'b0, 1'b0);
            locked_seen = lock;
        end
        check_bit("relock_within_budget", lock, 1'b1);
        for (int c = 0; c < 6; c++) begin
            if ((c % 2) == 0)
                drive(1'b1, 1'b1, MH, ML, 1'b0, 1'b0);
            else
                drive(1'b0, 1'b0, LH, LL, 1'b0, 1'b0);
            check_bit($sformatf("cadence_fp_c%0d", c), fp, (c % 2) == 1);
        end
        checks++;
        if (idata !== IA || qdata !== QA) begin
            failures++;
            $display("FAIL cadence_data: got i=%h q=%h expected i=%h q=%h", idata, qdata, IA, QA);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
